// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached RAM: command opcodes and default sizing.
package spi_ram_pkg;

    localparam int DEF_MEM_DEPTH = 256;
    localparam int DEF_ADDR_SIZE = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

endpackage

// File: rtl/spi_ram_ptr.sv
// Address pointer with valid flag: load (reduced modulo DEPTH), post-access
// increment, wrap from DEPTH-1 to 0. Used once for writes and once for reads.
module spi_ram_ptr
    import spi_ram_pkg::*;
#(
    parameter int DEPTH = DEF_MEM_DEPTH,
    parameter int WIDTH = DEF_ADDR_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr,
    output logic             vld
);

    // Pointer and valid flag; load wins over increment, reset wins over both.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            vld <= 1'b0;
        end else if (load) begin
            ptr <= WIDTH'(32'(load_val) % DEPTH);
            vld <= 1'b1;
        end else if (inc) begin
            ptr <= (ptr == WIDTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/spi_ram.sv
// Single-port RAM behind the SPI slave. Decodes 10-bit command words into
// address loads and data accesses with independent write/read pointers.
// Optional sticky err output for data commands issued before their address,
// enabled by defining SPI_RAM_ERR_EN.
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
`ifdef SPI_RAM_ERR_EN
    ,
    output logic       err
`endif
);

    logic [7:0]           mem [MEM_DEPTH];
    cmd_e                 cmd;
    logic                 wr_load, wr_inc, rd_load, rd_inc;
    logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
    logic                 wr_vld, rd_vld;

    assign cmd = cmd_e'(din[9:8]);

    // Command decode; data commands only take effect once their pointer is valid.
    always_comb begin
        wr_load = 1'b0;
        wr_inc  = 1'b0;
        rd_load = 1'b0;
        rd_inc  = 1'b0;
        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: wr_load = 1'b1;
                CMD_WR_DATA: wr_inc  = wr_vld;
                CMD_RD_ADDR: rd_load = 1'b1;
                CMD_RD_DATA: rd_inc  = rd_vld;
                default:     ;
            endcase
        end
    end

    spi_ram_ptr #(.DEPTH(MEM_DEPTH), .WIDTH(ADDR_SIZE)) u_wr_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (wr_load),
        .load_val (din[ADDR_SIZE-1:0]),
        .inc      (wr_inc),
        .ptr      (wr_ptr),
        .vld      (wr_vld)
    );

    spi_ram_ptr #(.DEPTH(MEM_DEPTH), .WIDTH(ADDR_SIZE)) u_rd_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (rd_load),
        .load_val (din[ADDR_SIZE-1:0]),
        .inc      (rd_inc),
        .ptr      (rd_ptr),
        .vld      (rd_vld)
    );

    // Memory write; array is never cleared, but a write in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_inc) begin
            mem[wr_ptr] <= din[7:0];
        end
    end

    // Registered read data and one-cycle tx_valid pulse per accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= rd_inc;
            if (rd_inc) begin
                dout <= mem[rd_ptr];
            end
        end
    end

`ifdef SPI_RAM_ERR_EN
    logic err_set;
    assign err_set = rx_valid && ((cmd == CMD_WR_DATA && !wr_vld) ||
                                  (cmd == CMD_RD_DATA && !rd_vld));

    // Sticky error flag for data commands issued before an address load.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_ram.sv
// Directed self-checking bench for spi_ram. Err checks are included when
// SPI_RAM_ERR_EN is defined.
module tb_spi_ram;

    logic       clk;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
`ifdef SPI_RAM_ERR_EN
    logic       err;
`endif

    int vectors    = 0;
    int miscompares = 0;

    spi_ram dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid)
`ifdef SPI_RAM_ERR_EN
        ,
        .err      (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present one command for one cycle; returns 1ns after the capturing edge.
    task automatic cmd(input logic [1:0] op, input logic [7:0] payload);
        @(negedge clk);
        rst      = 1'b0;
        din      = {op, payload};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        din      = 10'h000;
        rx_valid = 1'b0;

        // Reset state
        do_reset();
        check8("rst_dout", dout, 8'h00);
        check1("rst_tx", tx_valid, 1'b0);
`ifdef SPI_RAM_ERR_EN
        check1("rst_err", err, 1'b0);
`endif

        // Seed address 0 with 3C, then reset again (memory must survive)
        cmd(2'b00, 8'h00);
        cmd(2'b01, 8'h3C);
        do_reset();

        // RD_DATA with no RD_ADDR is ignored
        cmd(2'b11, 8'h00);
        check1("rd_novld_tx", tx_valid, 1'b0);
        check8("rd_novld_dout", dout, 8'h00);
`ifdef SPI_RAM_ERR_EN
        check1("rd_novld_err", err, 1'b1);
`endif

        // WR_DATA with no WR_ADDR is ignored, twice
        cmd(2'b01, 8'h77);
        cmd(2'b01, 8'h55);
        cmd(2'b10, 8'h00);
        check1("rdaddr_tx", tx_valid, 1'b0);
        cmd(2'b11, 8'h00);
        check1("wr_novld_tx", tx_valid, 1'b1);
        check8("wr_novld_dout", dout, 8'h3C);

        // Basic write then read at 0x10
        cmd(2'b00, 8'h10);
        cmd(2'b01, 8'hA5);
        cmd(2'b10, 8'h10);
        check1("basic_pre_tx", tx_valid, 1'b0);
        cmd(2'b11, 8'h00);
        check1("basic_tx", tx_valid, 1'b1);
        check8("basic_dout", dout, 8'hA5);
        idle_cycle();
        check1("basic_tx_pulse", tx_valid, 1'b0);
        check8("basic_dout_hold", dout, 8'hA5);

        // Burst across the wrap at 0xFF -> 0x00
        cmd(2'b00, 8'hFE);
        cmd(2'b01, 8'h11);
        cmd(2'b01, 8'h22);
        cmd(2'b01, 8'h33);
        cmd(2'b10, 8'hFE);
        cmd(2'b11, 8'h00);
        check1("burst0_tx", tx_valid, 1'b1);
        check8("burst0_dout", dout, 8'h11);
        cmd(2'b11, 8'h00);
        check1("burst1_tx", tx_valid, 1'b1);
        check8("burst1_dout", dout, 8'h22);
        cmd(2'b11, 8'h00);
        check1("burst2_tx", tx_valid, 1'b1);
        check8("burst2_dout", dout, 8'h33);
        cmd(2'b10, 8'h00);
        cmd(2'b11, 8'h00);
        check8("wrap_addr0", dout, 8'h33);

        // Pointer independence: write pointer is at 0x01 after the burst
        cmd(2'b10, 8'h10);
        cmd(2'b01, 8'h99);
        cmd(2'b00, 8'h55);
        cmd(2'b11, 8'h00);
        check8("indep_rd", dout, 8'hA5);
        cmd(2'b10, 8'h01);
        cmd(2'b11, 8'h00);
        check8("indep_wr", dout, 8'h99);

        // rx_valid low with an RD_DATA opcode on din for 5 cycles
        cmd(2'b10, 8'h10);
        @(negedge clk);
        din      = {2'b11, 8'h5A};
        rx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check1("idle_tx", tx_valid, 1'b0);
            check8("idle_dout", dout, 8'h99);
        end
        cmd(2'b11, 8'h00);
        check1("after_idle_tx", tx_valid, 1'b1);
        check8("after_idle_dout", dout, 8'hA5);

        // Reset coincident with an otherwise-accepted RD_DATA
        @(negedge clk);
        rst      = 1'b1;
        din      = {2'b11, 8'h00};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        check1("rst_rd_tx", tx_valid, 1'b0);
        check8("rst_rd_dout", dout, 8'h00);
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check1("post_rst_tx", tx_valid, 1'b0);
`ifdef SPI_RAM_ERR_EN
        check1("post_rst_err", err, 1'b0);
`endif
        cmd(2'b11, 8'h00);
        check1("rdvld_cleared_tx", tx_valid, 1'b0);
        check8("rdvld_cleared_dout", dout, 8'h00);

        idle_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
